// File: rtl/key_event_if.sv
// Key event bus: the debounced key level in, classified gesture events out.
interface key_event_if;
  logic       flag;
  logic       short_press;
  logic       long_press;
  logic       double_press;
  logic       held;
  logic [7:0] event_cnt;

  modport master (
    output flag,
    input  short_press, long_press, double_press, held, event_cnt
  );

  modport slave (
    input  flag,
    output short_press, long_press, double_press, held, event_cnt
  );
endinterface

// File: rtl/key_event_decoder.sv
// Classifies debounced key gestures into short/long/double press pulses with a wrapping count.
// Double-press detection is built only when KEY_DOUBLE_CLICK_EN is defined.
module key_event_decoder #(
  parameter int unsigned LONG_MS    = 1000,
  parameter int unsigned DBL_GAP_MS = 250
) (
  input logic         clk_1KHz,
  input logic         rst,
  key_event_if.slave  bus
);

  if (LONG_MS < 2 || LONG_MS > 2047) begin : g_bad_long_ms
    $error("LONG_MS out of range 2..2047");
  end
  if (DBL_GAP_MS < 2 || DBL_GAP_MS > 2047) begin : g_bad_dbl_gap_ms
    $error("DBL_GAP_MS out of range 2..2047");
  end

  localparam logic [10:0] LongLast = 11'(LONG_MS - 1);
`ifdef KEY_DOUBLE_CLICK_EN
  localparam logic [10:0] GapLast  = 11'(DBL_GAP_MS - 1);
`endif

  typedef enum logic [2:0] {
    StIdle,
    StPressed,
    StLongHeld
`ifdef KEY_DOUBLE_CLICK_EN
    ,
    StWaitSecond,
    StSecondPressed
`endif
  } state_e;

  state_e      state_q, state_d;
  logic [10:0] cnt_q, cnt_d;
  logic        prev_flag_q;
  logic        short_q, short_d;
  logic        long_q, long_d;
  logic        held_q, held_d;
  logic [7:0]  event_cnt_q, event_cnt_d;
  logic        rise;
  logic        count_en;
`ifdef KEY_DOUBLE_CLICK_EN
  logic        dbl_q, dbl_d;
`endif

  assign rise = bus.flag & ~prev_flag_q;

  always_comb begin
    state_d  = state_q;
    short_d  = 1'b0;
    long_d   = 1'b0;
    count_en = 1'b0;
`ifdef KEY_DOUBLE_CLICK_EN
    dbl_d    = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (rise) state_d = StPressed;
      end
      StPressed: begin
        count_en = bus.flag;
        // Release is tested first so it beats a coincident long threshold.
        if (!bus.flag) begin
`ifdef KEY_DOUBLE_CLICK_EN
          state_d = StWaitSecond;
`else
          short_d = 1'b1;
          state_d = StIdle;
`endif
        end else if (cnt_q == LongLast) begin
          long_d  = 1'b1;
          state_d = StLongHeld;
        end
      end
      StLongHeld: begin
        if (!bus.flag) state_d = StIdle;
      end
`ifdef KEY_DOUBLE_CLICK_EN
      StWaitSecond: begin
        count_en = ~bus.flag;
        if (rise) begin
          state_d = StSecondPressed;
        end else if (cnt_q == GapLast) begin
          short_d = 1'b1;
          state_d = StIdle;
        end
      end
      StSecondPressed: begin
        if (!bus.flag) begin
          dbl_d   = 1'b1;
          state_d = StIdle;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (count_en && (cnt_q != 11'h7FF)) begin
      cnt_d = cnt_q + 11'd1;
    end
  end

  always_comb begin
    held_d      = (state_d == StLongHeld);
    event_cnt_d = event_cnt_q;
`ifdef KEY_DOUBLE_CLICK_EN
    if (short_d || long_d || dbl_d) event_cnt_d = event_cnt_q + 8'd1;
`else
    if (short_d || long_d) event_cnt_d = event_cnt_q + 8'd1;
`endif
  end

  always_ff @(posedge clk_1KHz) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      // Starting high hides a key already held when reset is released.
      prev_flag_q <= 1'b1;
      short_q     <= 1'b0;
      long_q      <= 1'b0;
      held_q      <= 1'b0;
      event_cnt_q <= '0;
`ifdef KEY_DOUBLE_CLICK_EN
      dbl_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      prev_flag_q <= bus.flag;
      short_q     <= short_d;
      long_q      <= long_d;
      held_q      <= held_d;
      event_cnt_q <= event_cnt_d;
`ifdef KEY_DOUBLE_CLICK_EN
      dbl_q       <= dbl_d;
`endif
    end
  end

  assign bus.short_press  = short_q;
  assign bus.long_press   = long_q;
  assign bus.held         = held_q;
  assign bus.event_cnt    = event_cnt_q;
`ifdef KEY_DOUBLE_CLICK_EN
  assign bus.double_press = dbl_q;
`else
  assign bus.double_press = 1'b0;
`endif

endmodule

// File: tb/tb_key_event_decoder.sv
// Scoreboard bench for key_event_decoder; expected pulses are queued with their cycle and count.
module tb_key_event_decoder;

  localparam int LongMs = 20;
  localparam int GapMs  = 8;
`ifdef KEY_DOUBLE_CLICK_EN
  localparam int ShortLat = GapMs + 1;
`else
  localparam int ShortLat = 1;
`endif
  localparam int KShort = 0;
  localparam int KLong  = 1;
  localparam int KDbl   = 2;

  logic clk_1KHz = 1'b0;
  logic rst      = 1'b1;

  key_event_if bus ();

  key_event_decoder #(
    .LONG_MS    (LongMs),
    .DBL_GAP_MS (GapMs)
  ) dut (
    .clk_1KHz (clk_1KHz),
    .rst      (rst),
    .bus      (bus)
  );

  always #5 clk_1KHz = ~clk_1KHz;

  int cyc = 0;
  always @(posedge clk_1KHz) cyc <= cyc + 1;

  typedef struct {
    int kind;
    int at;
    int cnt;
  } ev_t;

  ev_t exp_q[$];
  int  exp_cnt = 0;
  int  checks  = 0;
  int  errors  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push(input int kind, input int at);
    exp_cnt = (exp_cnt + 1) % 256;
    exp_q.push_back(ev_t'{kind, at, exp_cnt});
  endtask

  // Bench stays aligned 1 time unit after a rising edge; each step is one cycle.
  task automatic hold(input logic v, input int n);
    repeat (n) begin
      bus.flag = v;
      @(posedge clk_1KHz);
      #1;
    end
  endtask

  // Isolated short gesture starting and ending with the key released.
  task automatic tap(input int hi);
    hold(1'b1, hi);
    push(KShort, cyc + ShortLat);
    hold(1'b0, ShortLat);
  endtask

  task automatic drain;
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(posedge clk_1KHz);
      #1;
      t++;
    end
    if (exp_q.size() != 0) begin
      check("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
    hold(1'b0, 2);
  endtask

  task automatic do_reset;
    rst      = 1'b1;
    bus.flag = 1'b0;
    repeat (3) @(posedge clk_1KHz);
    #1;
    rst     = 1'b0;
    exp_cnt = 0;
    hold(1'b0, 2);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_short"}, bus.short_press, 0);
    check({tag, "_long"}, bus.long_press, 0);
    check({tag, "_double"}, bus.double_press, 0);
    check({tag, "_held"}, bus.held, 0);
    check({tag, "_event_cnt"}, bus.event_cnt, 0);
  endtask

  always @(negedge clk_1KHz) begin : mon
    int  n;
    int  k;
    ev_t e;
    n = int'(bus.short_press) + int'(bus.long_press) + int'(bus.double_press);
    if (n != 0) begin
      check("onehot", n, 1);
      k = bus.short_press ? KShort : (bus.long_press ? KLong : KDbl);
      if (exp_q.size() == 0) begin
        check("spurious_pulse", {bus.short_press, bus.long_press, bus.double_press}, 0);
      end else begin
        e = exp_q.pop_front();
        check("kind", k, e.kind);
        check("pulse_cycle", cyc, e.at);
        check("event_cnt", bus.event_cnt, e.cnt);
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL global_timeout: simulation still running (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

  initial begin : stim
    int c0;
    bus.flag = 1'b0;
    do_reset();
    check_quiet("reset");

    // Short press with the release exactly in the long-threshold cycle.
    tap(5);
    tap(LongMs);
    drain();

    // Long press: pulse at P+LONG_MS, held until the cycle after release.
    c0 = cyc;
    push(KLong, c0 + 1 + LongMs);
    for (int k = 0; k < 32; k++) begin
      check("held_long", bus.held, (k >= LongMs + 1 && k <= 30) ? 1 : 0);
      bus.flag = (k < 30);
      @(posedge clk_1KHz);
      #1;
    end
    drain();

    // One cycle past the boundary gives a long press.
    push(KLong, cyc + 1 + LongMs);
    hold(1'b1, LongMs + 1);
    hold(1'b0, 2);
    drain();

`ifdef KEY_DOUBLE_CLICK_EN
    do_reset();
    // Double press.
    hold(1'b1, 4);
    hold(1'b0, 3);
    hold(1'b1, 4);
    push(KDbl, cyc + 1);
    hold(1'b0, ShortLat);
    drain();
    check("dbl_event_cnt", bus.event_cnt, 1);

    // Second rise lands on the gap-timeout cycle: still a double.
    hold(1'b1, 4);
    hold(1'b0, GapMs);
    hold(1'b1, 3);
    push(KDbl, cyc + 1);
    hold(1'b0, ShortLat);
    drain();

    // Gap expires, and a rise in the following IDLE cycle starts a new gesture.
    hold(1'b1, 4);
    push(KShort, cyc + GapMs + 1);
    hold(1'b0, GapMs + 1);
    tap(3);
    drain();

    // Reset while waiting for a second press drops the pending short.
    hold(1'b1, 4);
    hold(1'b0, 3);
    rst = 1'b1;
    @(posedge clk_1KHz);
    #1;
    check_quiet("rst_wait_second");
    rst     = 1'b0;
    exp_cnt = 0;
    hold(1'b0, 15);
`else
    // High 5, low 2, high 5: two shorts, each one cycle after release.
    hold(1'b1, 5);
    push(KShort, cyc + 1);
    hold(1'b0, 2);
    hold(1'b1, 5);
    push(KShort, cyc + 1);
    hold(1'b0, 2);
    // Rise in the very first IDLE cycle after a short is honoured.
    hold(1'b1, 3);
    push(KShort, cyc + 1);
    hold(1'b0, 1);
    tap(3);
    drain();

    // Reset mid-press drops the gesture.
    hold(1'b1, 4);
    rst      = 1'b1;
    bus.flag = 1'b0;
    @(posedge clk_1KHz);
    #1;
    check_quiet("rst_pressed");
    rst     = 1'b0;
    exp_cnt = 0;
    hold(1'b0, 5);
`endif

    // Reset during LONG_HELD.
    push(KLong, cyc + 1 + LongMs);
    hold(1'b1, LongMs + 5);
    rst      = 1'b1;
    bus.flag = 1'b0;
    @(posedge clk_1KHz);
    #1;
    check_quiet("rst_long_held");
    rst     = 1'b0;
    exp_cnt = 0;
    hold(1'b0, 3);
    drain();

    // Key held through reset deassert is ignored until re-pressed.
    rst = 1'b1;
    hold(1'b1, 3);
    rst     = 1'b0;
    exp_cnt = 0;
    hold(1'b1, LongMs + 10);
    check("held_through_reset", bus.held, 0);
    hold(1'b0, ShortLat + 2);
    check("no_event_after_reset_hold", bus.event_cnt, 0);
    tap(3);
    drain();

    // 256 shorts wrap the event counter back to zero.
    do_reset();
    for (int i = 0; i < 256; i++) begin
      tap(2);
    end
    drain();
    check("wrap_event_cnt", bus.event_cnt, 0);

    check("pending_events", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
